// File: rtl/sumador_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the sizing helper for the bit counter.
package sumador_pkg;

  // Operand width used when the block is instantiated without overrides.
  localparam int DEFAULT_WIDTH = 4;

  // Controller states: waiting for a request, stepping bits, completion pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width for a given operand width. The counter only has to
  // reach WIDTH-1, so $clog2(WIDTH) bits are enough; never less than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage : sumador_pkg

// File: rtl/sumador1b.sv
// One-bit full adder. Purely combinational; the serial adder instantiates
// it once and feeds it the operand LSBs plus the registered carry.
module sumador1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half_sum;

  // Propagate term shared by the sum and the carry equations.
  assign half_sum = a ^ b;

  // Sum bit and carry-out (generate, or propagate an incoming carry).
  assign s  = half_sum ^ ci;
  assign co = (a & b) | (ci & half_sum);

endmodule : sumador1b

// File: rtl/sumador_serie.sv
// Bit-serial adder: A + B + carry-in, one bit per clock through a single
// full-adder stage. Start/done handshake; all outputs are registered.
module sumador_serie
  import sumador_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co,
  output logic             out_ov,
  output logic             out_busy,
  output logic             out_done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;       // operand A, consumed LSB first
  logic [WIDTH-1:0] b_q;       // operand B, consumed LSB first
  logic [WIDTH-1:0] sum_q;     // partial sum, filled from the MSB side
  logic             carry_q;   // carry into the bit being added this cycle
  logic [CW-1:0]    cnt_q;     // index of the bit being added this cycle

  logic             s_bit;
  logic             c_next;
  logic             last_step;
  logic [WIDTH-1:0] sum_next;

  // Single full-adder stage working on the current operand LSBs.
  sumador1b u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (s_bit),
    .co (c_next)
  );

  // After WIDTH right-shifts the first computed bit has reached bit 0,
  // so the register holds the sum in natural order.
  assign sum_next  = {s_bit, sum_q[WIDTH-1:1]};
  assign last_step = (cnt_q == LAST_BIT);

  // Controller, datapath registers and output registers in one process so
  // every output is a flop with no path back to the inputs.
  // NOTE: sequential state uses non-blocking (<=) so all flops update from
  // the same pre-edge values; blocking here would chain the shift registers.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    // NOTE: every register, the working shift registers included, is reset;
    // they are small and a reset mid-operation must leave no stale bits.
    if (!in_rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      out_s    <= '0;
      out_co   <= 1'b0;
      out_ov   <= 1'b0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Operands are captured only here; later changes cannot matter.
          if (in_start) begin
            a_q      <= in_a;
            b_q      <= in_b;
            sum_q    <= '0;
            carry_q  <= in_ci;
            cnt_q    <= '0;
            out_busy <= 1'b1;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          sum_q   <= sum_next;
          carry_q <= c_next;
          cnt_q   <= cnt_q + 1'b1;
          if (last_step) begin
            // carry_q is the carry into the MSB here, c_next the carry out.
            out_s    <= sum_next;
            out_co   <= c_next;
            out_ov   <= carry_q ^ c_next;
            out_done <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          // Single-cycle pulse; a start seen here is dropped, not queued.
          out_done <= 1'b0;
          out_busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          out_done <= 1'b0;
          out_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule : sumador_serie
